// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: requester and SRAM bus signals shared by the arbiter and its environment.
interface sram_arbiter_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_data_ok;
    logic        data_req;
    logic [3:0]  data_wen;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_data_ok;
    logic        bus_req;
    logic [3:0]  bus_wen;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;
    logic        stallreq_if;
    logic        stallreq_mem;
    modport slave (
        input  inst_req, inst_addr, data_req, data_wen, data_addr, data_wdata,
               bus_addr_ok, bus_data_ok, bus_rdata,
        output inst_rdata, inst_data_ok, data_rdata, data_data_ok,
               bus_req, bus_wen, bus_addr, bus_wdata, stallreq_if, stallreq_mem
    );
    modport master (
        output inst_req, inst_addr, data_req, data_wen, data_addr, data_wdata,
               bus_addr_ok, bus_data_ok, bus_rdata,
        input  inst_rdata, inst_data_ok, data_rdata, data_data_ok,
               bus_req, bus_wen, bus_addr, bus_wdata, stallreq_if, stallreq_mem
    );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one SRAM bus port between IF and MEM with round-robin on contention.
module sram_arbiter (
    input logic         clk,
    input logic         rst,
    sram_arbiter_if.slave sif
);
    typedef enum logic [2:0] {IDLE, INST_ADDR, INST_WAIT, DATA_ADDR, DATA_WAIT} state_t;
    state_t state;
    logic   last_grant;
    logic   inst_v;
    logic   data_v;
    logic   grant_inst;
    logic   grant_data;
    // a requester whose completion pulse is high is finishing, so it must not be re-granted
    always_comb begin
        inst_v     = sif.inst_req & ~sif.inst_data_ok;
        data_v     = sif.data_req & ~sif.data_data_ok;
        grant_data = data_v & (~inst_v | ~last_grant);
        grant_inst = inst_v & ~grant_data;
    end
    assign sif.stallreq_if  = inst_v;
    assign sif.stallreq_mem = data_v;
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            last_grant       <= 1'b1;
            sif.bus_req      <= 1'b0;
            sif.bus_wen      <= 4'b0;
            sif.bus_addr     <= 32'b0;
            sif.bus_wdata    <= 32'b0;
            sif.inst_rdata   <= 32'b0;
            sif.data_rdata   <= 32'b0;
            sif.inst_data_ok <= 1'b0;
            sif.data_data_ok <= 1'b0;
        end else begin
            sif.inst_data_ok <= 1'b0;
            sif.data_data_ok <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_data | grant_inst) begin
                        state         <= grant_data ? DATA_ADDR : INST_ADDR;
                        last_grant    <= grant_data;
                        sif.bus_req   <= 1'b1;
                        sif.bus_addr  <= grant_data ? sif.data_addr : sif.inst_addr;
                        sif.bus_wen   <= grant_data ? sif.data_wen : 4'b0;
                        sif.bus_wdata <= grant_data ? sif.data_wdata : 32'b0;
                    end
                end
                INST_ADDR, DATA_ADDR: begin
                    if (sif.bus_addr_ok) begin
                        state       <= (state == INST_ADDR) ? INST_WAIT : DATA_WAIT;
                        sif.bus_req <= 1'b0;
                    end
                end
                INST_WAIT: begin
                    if (sif.bus_data_ok) begin
                        state            <= IDLE;
                        sif.inst_data_ok <= 1'b1;
                        sif.inst_rdata   <= sif.bus_rdata;
                    end
                end
                DATA_WAIT: begin
                    if (sif.bus_data_ok) begin
                        state            <= IDLE;
                        sif.data_data_ok <= 1'b1;
                        if (sif.bus_wen == 4'b0) sif.data_rdata <= sif.bus_rdata;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
